dm_ctrl: RTL and testbench
==========================

Name: dm_ctrl

Overview:
- Initiator-side controller for the SISC data memory (dm).
- Accepts single load/store requests from the CPU datapath over a valid/ready handshake.
- Sequences the dm read address, write address/data and the dm_we pulse. dm commits writes on the falling edge of dm_we and reads combinationally from read_addr.
- Returns load data or a store acknowledge over a valid/ready response channel. One transaction outstanding at a time.

Parameters:
- RD_LAT, 1: clock cycles between driving dm_read_addr and capturing dm_read_data; legal range 1..15.
- WE_WIDTH, 1: clock cycles dm_we is held high per store; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  16  word address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  CPU accepts response.
- rsp_is_write  out  1  1 = store acknowledge, 0 = load data.
- rsp_rdata  out  32  load data; 0 for store acknowledge.
- dm_read_addr  out  16  to dm read_addr.
- dm_write_addr  out  16  to dm write_addr.
- dm_write_data  out  32  to dm write_data.
- dm_we  out  1  to dm dm_we; falling edge commits the write.
- dm_read_data  in  32  from dm read_data.

Behaviour:
- States: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, RSP. Reset state is IDLE.
- Reset values: rsp_valid=0, rsp_is_write=0, rsp_rdata=0, dm_read_addr=0, dm_we=0, internal counter=0.
  - dm_write_addr and dm_write_data are not reset; they are X until the first store.
  - If reset asserts while dm_we=1, the forced falling edge commits the held address/data in dm. This is defined behaviour.
- req_ready = (state==IDLE), combinational. A request is accepted on a rising edge with req_valid && req_ready. req_valid while busy is ignored and must be held by the CPU.
- Load, accepted at edge 0:
  - dm_read_addr <= req_addr at edge 0; counter <= RD_LAT-1; enter RD_WAIT.
  - In RD_WAIT, the counter decrements each edge.
  - At the edge where the counter is 0: rsp_rdata <= dm_read_data, rsp_is_write <= 0, rsp_valid <= 1, enter RSP.
  - rsp_valid is first high after edge RD_LAT.
- Store, accepted at edge 0:
  - dm_write_addr <= req_addr and dm_write_data <= req_wdata at edge 0; enter WR_SETUP with dm_we=0 (one setup cycle).
  - Edge 1: dm_we <= 1, counter <= WE_WIDTH-1, enter WR_PULSE.
  - Edge at counter 0: dm_we <= 0 (commit point), enter WR_HOLD. Address and data stay stable through WR_HOLD.
  - Next edge: rsp_valid <= 1, rsp_is_write <= 1, rsp_rdata <= 0, enter RSP.
  - rsp_valid is first high after edge WE_WIDTH+2 (edge 3 by default).
- dm_write_addr and dm_write_data change only at store acceptance. dm_read_addr changes only at load acceptance; each holds its value otherwise.
- RSP:
  - rsp_valid, rsp_rdata and rsp_is_write are held stable until an edge with rsp_ready=1.
  - On that edge: rsp_valid <= 0, enter IDLE.
  - req_ready stays 0 during RSP, so a new request is accepted no earlier than the edge after the handshake edge. Minimum inter-load spacing is RD_LAT+2 edges.
- rsp_ready asserted outside RSP has no effect.
- Read-after-write: a load that follows a store sees the new data, because the commit precedes the store response.
- dm_we is never high in any state other than WR_PULSE, and dm_we glitches are not permitted; it is a registered output.
- The counter is 4 bits and never wraps; parameters outside 1..15 are illegal.

Test Plan:
- Reset: assert rst mid-cycle -> immediately rsp_valid=0, dm_we=0, dm_read_addr=0, req_ready=1 after release.
- Load, RD_LAT=1: dm holds 0x0000_00AB at address 8; request load addr 8 at edge 0 -> dm_read_addr=8 after edge 0; rsp_valid=1 with rsp_rdata=0x0000_00AB and rsp_is_write=0 after edge 1.
- Store then load-back: store 0xDEADBEEF to addr 9 -> dm_we high exactly one cycle (edges 1-2); rsp_valid with rsp_is_write=1 and rsp_rdata=0 after edge 3. Then load addr 9 -> rsp_rdata=0xDEADBEEF.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load response -> rsp_valid and rsp_rdata stable, req_ready=0, a second req_valid is not accepted. Release -> IDLE on the next edge, second request accepted one edge later.
- WE_WIDTH=3 with reset mid-pulse: store 0x12345678 to addr 1 and assert rst during the 2nd high cycle -> dm_we falls asynchronously, dm address 1 reads 0x12345678, state IDLE, no response issued.
- Busy request ignored: pulse req_valid for one cycle during WR_PULSE with addr 2 -> no dm activity for addr 2, exactly one response total.

Source files
------------

// File: rtl/dm_ctrl_if.sv
// Bundles the CPU request/response channels and the dm port of the data-memory controller.
// The master side is the CPU plus the dm array; the slave side is dm_ctrl.
interface dm_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_is_write;
  logic [31:0] rsp_rdata;
  logic [15:0] dm_read_addr;
  logic [15:0] dm_write_addr;
  logic [31:0] dm_write_data;
  logic        dm_we;
  logic [31:0] dm_read_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, dm_read_data,
    input  req_ready, rsp_valid, rsp_is_write, rsp_rdata,
           dm_read_addr, dm_write_addr, dm_write_data, dm_we
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, dm_read_data,
    output req_ready, rsp_valid, rsp_is_write, rsp_rdata,
           dm_read_addr, dm_write_addr, dm_write_data, dm_we
  );
endinterface

// File: rtl/dm_ctrl.sv
// Data-memory initiator: one load/store at a time, sequences dm read address,
// write address/data and a registered dm_we pulse, then returns a response.
//
// state    | meaning
// IDLE     | ready for a request
// RD_WAIT  | waiting RD_LAT cycles for dm read data
// WR_SETUP | write address/data settle with dm_we low
// WR_PULSE | dm_we high for WE_WIDTH cycles
// WR_HOLD  | dm_we low again, address/data still stable
// RSP      | response held until rsp_ready
module dm_ctrl #(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned WE_WIDTH = 1
) (
  input  logic      clk,
  input  logic      rst,
  dm_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, RSP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        we_q, we_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_is_write_q, rsp_is_write_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rd_addr_q      <= '0;
      we_q           <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_is_write_q <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rd_addr_q      <= rd_addr_d;
      we_q           <= we_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_is_write_q <= rsp_is_write_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

  // Write address/data stay untouched by reset so an in-flight pulse cut by reset commits them.
  always_ff @(posedge clk) begin
    wr_addr_q <= wr_addr_d;
    wr_data_q <= wr_data_d;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rd_addr_d      = rd_addr_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    we_d           = we_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_is_write_d = rsp_is_write_q;
    rsp_rdata_d    = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_we) begin
            wr_addr_d = bus.req_addr;
            wr_data_d = bus.req_wdata;
            state_d   = WR_SETUP;
          end else begin
            rd_addr_d = bus.req_addr;
            cnt_d     = 4'(RD_LAT - 1);
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_rdata_d    = bus.dm_read_data;
          rsp_is_write_d = 1'b0;
          rsp_valid_d    = 1'b1;
          state_d        = RSP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_SETUP: begin
        we_d    = 1'b1;
        cnt_d   = 4'(WE_WIDTH - 1);
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_q == 4'd0) begin
          we_d    = 1'b0;
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_HOLD: begin
        rsp_valid_d    = 1'b1;
        rsp_is_write_d = 1'b1;
        rsp_rdata_d    = '0;
        state_d        = RSP;
      end
      RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready     = (state_q == IDLE);
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_is_write  = rsp_is_write_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.dm_read_addr  = rd_addr_q;
  assign bus.dm_write_addr = wr_addr_q;
  assign bus.dm_write_data = wr_data_q;
  assign bus.dm_we         = we_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: table of load/store vectors through a response scoreboard,
// plus hand sequences for backpressure, reset, busy requests and a WE_WIDTH=3 instance.
module tb_dm_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  dm_ctrl_if b0 ();
  dm_ctrl_if b1 ();

  dm_ctrl #(.RD_LAT(1), .WE_WIDTH(1)) u0 (.clk(clk), .rst(rst),  .bus(b0.slave));
  dm_ctrl #(.RD_LAT(2), .WE_WIDTH(3)) u1 (.clk(clk), .rst(rst1), .bus(b1.slave));

  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];
  bit armed0 = 0;
  bit armed1 = 0;

  assign b0.dm_read_data = mem0[b0.dm_read_addr[7:0]];
  assign b1.dm_read_data = mem1[b1.dm_read_addr[7:0]];

  always @(negedge b0.dm_we) if (armed0) mem0[b0.dm_write_addr[7:0]] = b0.dm_write_data;
  always @(negedge b1.dm_we) if (armed1) mem1[b1.dm_write_addr[7:0]] = b1.dm_write_data;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  typedef struct packed {
    logic        is_write;
    logic [31:0] rdata;
  } rsp_t;
  rsp_t exp_q[$];
  rsp_t e;
  int   rsp_cnt0 = 0;
  int   we_hi0   = 0;
  bit   rsp1_seen = 0;

  always @(negedge clk) begin
    if (!rst && b0.rsp_valid && b0.rsp_ready) begin
      rsp_cnt0++;
      if (exp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_cnt0), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_is_write", 32'(b0.rsp_is_write), 32'(e.is_write));
        chk("rsp_rdata", b0.rsp_rdata, e.rdata);
      end
    end
    if (b0.dm_we) we_hi0++;
    if (b1.rsp_valid) rsp1_seen = 1;
  end

  task automatic do_req(input logic we, input logic [15:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input int exp_lat);
    int lat;
    int we_start;
    bit got;
    @(posedge clk); #1;
    b0.req_valid = 1'b1; b0.req_we = we; b0.req_addr = a; b0.req_wdata = d;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (b0.req_ready) got = 1;
    end
    if (!got) chk("req_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    exp_q.push_back('{is_write: we, rdata: exp_rdata});
    if (we) armed0 = 1;
    we_start = we_hi0;
    #1 b0.req_valid = 1'b0;
    if (we) begin
      chk("dm_write_addr", 32'(b0.dm_write_addr), 32'(a));
      chk("dm_write_data", b0.dm_write_data, d);
    end else begin
      chk("dm_read_addr", 32'(b0.dm_read_addr), 32'(a));
    end
    lat = 0;
    while (!b0.rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    if (we) chk("dm_we_width", 32'(we_hi0 - we_start), 32'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;
  vec_t vt[6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int cnt_before;
    for (int i = 0; i < 256; i++) begin mem0[i] = 32'h0; mem1[i] = 32'h0; end
    mem0[8] = 32'h0000_00AB;
    mem0[4] = 32'h0000_0044;
    mem0[2] = 32'h0000_2222;
    b0.req_valid = 0; b0.req_we = 0; b0.req_addr = 0; b0.req_wdata = 0; b0.rsp_ready = 1;
    b1.req_valid = 0; b1.req_we = 0; b1.req_addr = 0; b1.req_wdata = 0; b1.rsp_ready = 1;

    vt[0] = '{1'b0, 16'd8, 32'h0,         32'h0000_00AB, 1};
    vt[1] = '{1'b1, 16'd9, 32'hDEADBEEF,  32'h0,         3};
    vt[2] = '{1'b0, 16'd9, 32'h0,         32'hDEADBEEF,  1};
    vt[3] = '{1'b1, 16'd3, 32'h55AA55AA,  32'h0,         3};
    vt[4] = '{1'b0, 16'd3, 32'h0,         32'h55AA55AA,  1};
    vt[5] = '{1'b0, 16'd4, 32'h0,         32'h0000_0044, 1};

    repeat (3) @(posedge clk);
    #1 rst = 0; rst1 = 0;
    chk("rst_req_ready", 32'(b0.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(b0.rsp_valid), 32'd0);
    chk("rst_dm_we", 32'(b0.dm_we), 32'd0);
    chk("rst_dm_read_addr", 32'(b0.dm_read_addr), 32'd0);
    chk("rst_rsp_rdata", b0.rsp_rdata, 32'd0);

    for (int i = 0; i < 6; i++)
      do_req(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, vt[i].exp_lat);

    // Backpressure: response held, second request waits until the edge after the handshake.
    b0.rsp_ready = 0;
    @(posedge clk); #1;
    b0.req_valid = 1; b0.req_we = 0; b0.req_addr = 16'd8;
    @(posedge clk);
    exp_q.push_back('{is_write: 1'b0, rdata: 32'h0000_00AB});
    #1 b0.req_addr = 16'd9;
    lat = 0;
    while (!b0.rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp_first_latency", 32'(lat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(b0.rsp_valid), 32'd1);
      chk("bp_rsp_rdata", b0.rsp_rdata, 32'h0000_00AB);
      chk("bp_req_ready", 32'(b0.req_ready), 32'd0);
      chk("bp_read_addr", 32'(b0.dm_read_addr), 32'd8);
    end
    @(posedge clk); #1 b0.rsp_ready = 1;
    @(posedge clk); #1;
    chk("bp_idle_req_ready", 32'(b0.req_ready), 32'd1);
    chk("bp_idle_rsp_valid", 32'(b0.rsp_valid), 32'd0);
    chk("bp_not_yet_taken", 32'(b0.dm_read_addr), 32'd8);
    @(posedge clk);
    exp_q.push_back('{is_write: 1'b0, rdata: 32'hDEADBEEF});
    #1;
    chk("bp_second_addr", 32'(b0.dm_read_addr), 32'd9);
    chk("bp_second_busy", 32'(b0.req_ready), 32'd0);
    b0.req_valid = 0;
    lat = 0;
    while (!b0.rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp_second_latency", 32'(lat), 32'd1);
    @(posedge clk); #1;

    // Busy request during WR_PULSE must be ignored.
    cnt_before = rsp_cnt0;
    @(posedge clk); #1;
    b0.req_valid = 1; b0.req_we = 1; b0.req_addr = 16'd5; b0.req_wdata = 32'h0BADF00D;
    @(posedge clk);
    exp_q.push_back('{is_write: 1'b1, rdata: 32'h0});
    armed0 = 1;
    #1 b0.req_valid = 0;
    @(posedge clk); #1;
    chk("busy_we_high", 32'(b0.dm_we), 32'd1);
    b0.req_valid = 1; b0.req_we = 1; b0.req_addr = 16'd2; b0.req_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    b0.req_valid = 0;
    chk("busy_write_addr", 32'(b0.dm_write_addr), 32'd5);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_mem2_untouched", mem0[2], 32'h0000_2222);
    chk("busy_mem5_written", mem0[5], 32'h0BADF00D);
    chk("busy_one_rsp", 32'(rsp_cnt0 - cnt_before), 32'd1);

    // Mid-cycle reset while a load response is pending.
    b0.rsp_ready = 0;
    @(posedge clk); #1;
    b0.req_valid = 1; b0.req_we = 0; b0.req_addr = 16'd4;
    @(posedge clk); #1 b0.req_valid = 0;
    lat = 0;
    while (!b0.rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    @(negedge clk); #2 rst = 1;
    #1;
    chk("mid_rst_rsp_valid", 32'(b0.rsp_valid), 32'd0);
    chk("mid_rst_dm_we", 32'(b0.dm_we), 32'd0);
    chk("mid_rst_read_addr", 32'(b0.dm_read_addr), 32'd0);
    chk("mid_rst_rsp_rdata", b0.rsp_rdata, 32'd0);
    @(posedge clk); #1 rst = 0; b0.rsp_ready = 1;
    chk("mid_rst_req_ready", 32'(b0.req_ready), 32'd1);

    // WE_WIDTH=3 instance: reset during the 2nd high cycle of dm_we.
    @(posedge clk); #1;
    b1.req_valid = 1; b1.req_we = 1; b1.req_addr = 16'd1; b1.req_wdata = 32'h12345678;
    @(posedge clk);
    armed1 = 1;
    #1 b1.req_valid = 0;
    @(posedge clk); #1;
    chk("w3_we_first", 32'(b1.dm_we), 32'd1);
    @(posedge clk); #2;
    chk("w3_we_second", 32'(b1.dm_we), 32'd1);
    chk("w3_not_committed_yet", mem1[1], 32'h0);
    #1 rst1 = 1;
    #1;
    chk("w3_rst_we_low", 32'(b1.dm_we), 32'd0);
    chk("w3_rst_commit", mem1[1], 32'h12345678);
    chk("w3_rst_idle", 32'(b1.req_ready), 32'd1);
    @(posedge clk); #1 rst1 = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("w3_no_response", 32'(rsp1_seen), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
